// File: rtl/bram_scan_pkg.sv
// Shared types and constants for the bram port-B scan reader.
package bram_scan_pkg;

    localparam int DEFAULT_WIDTH = 16;

    // Address bits [9:8] equal to this select the switch/I-O region in the top-level read mux.
    localparam logic [1:0] IO_SEL_BITS = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        HOLD = 2'b10
    } scan_state_e;

    function automatic logic is_io_sel(input logic [1:0] sel);
        return (sel == IO_SEL_BITS);
    endfunction

endpackage

// File: rtl/scan_lat_counter.sv
// Read-latency wait counter: load on entry to WAIT, count down while enabled,
// expired when the port-B read data is valid.
module scan_lat_counter #(
    parameter int READ_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam logic [1:0] LOAD_VAL = 2'(READ_LAT - 1);

    logic [1:0] cnt_r;

    // Countdown register; a load always wins over a decrement.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= 2'd0;
        end else if (load) begin
            cnt_r <= LOAD_VAL;
        end else if (en && (cnt_r != 2'd0)) begin
            cnt_r <= cnt_r - 2'd1;
        end
    end

    assign expired = (cnt_r == 2'd0);

endmodule

// File: rtl/bram_scan_reader.sv
// Port-B read-only scanner: streams a contiguous bram word range out as valid/ready.
// Define SCAN_LOOP_EN to make the scan restart from the latched base/length until stopped.
module bram_scan_reader
    import bram_scan_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int READ_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] base_addr,
    input  logic [WIDTH-1:0] length,
    output logic [WIDTH-1:0] addr_b,
    output logic             we_b,
    output logic [WIDTH-1:0] data_b,
    input  logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    scan_state_e      state_r, state_s;
    logic [WIDTH-1:0] addr_r, addr_s;
    logic [WIDTH-1:0] rem_r, rem_s;
    logic [WIDTH-1:0] data_r, data_s;
    logic             valid_r, valid_s;
    logic             done_r, done_s;
    logic             lat_load_s, lat_en_s, lat_expired_s;
`ifdef SCAN_LOOP_EN
    logic [WIDTH-1:0] base_copy_r, len_copy_r;
`endif

    scan_lat_counter #(
        .READ_LAT (READ_LAT)
    ) u_lat (
        .clk     (clk),
        .reset   (reset),
        .load    (lat_load_s),
        .en      (lat_en_s),
        .expired (lat_expired_s)
    );

    // Next-state and datapath decode; stop outranks both start and handshake.
    always_comb begin
        state_s    = state_r;
        addr_s     = addr_r;
        rem_s      = rem_r;
        data_s     = data_r;
        valid_s    = valid_r;
        done_s     = 1'b0;
        lat_load_s = 1'b0;
        lat_en_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (stop) begin
                    state_s = IDLE;
                end else if (start) begin
                    if (length != ZERO) begin
                        addr_s     = base_addr;
                        rem_s      = length;
                        lat_load_s = 1'b1;
                        state_s    = WAIT;
                    end else begin
                        done_s = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (stop) begin
                    valid_s = 1'b0;
                    state_s = IDLE;
                end else begin
                    lat_en_s = 1'b1;
                    if (lat_expired_s) begin
                        data_s  = rd_data;
                        valid_s = 1'b1;
                        state_s = HOLD;
                    end else begin
                        state_s = WAIT;
                    end
                end
            end
            HOLD: begin
                if (stop) begin
                    valid_s = 1'b0;
                    state_s = IDLE;
                end else if (out_ready) begin
                    valid_s    = 1'b0;
                    lat_load_s = 1'b1;
                    state_s    = WAIT;
                    if (rem_r == ONE) begin
                        done_s = 1'b1;
`ifdef SCAN_LOOP_EN
                        addr_s = base_copy_r;
                        rem_s  = len_copy_r;
`else
                        lat_load_s = 1'b0;
                        state_s    = IDLE;
`endif
                    end else begin
                        // Address wraps modulo 2^WIDTH by plain truncation.
                        addr_s = addr_r + ONE;
                        rem_s  = rem_r - ONE;
                    end
                end else begin
                    valid_s = 1'b1;
                end
            end
            default: begin
                valid_s = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Registered address, counters and stream outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_r  <= ZERO;
            rem_r   <= ZERO;
            data_r  <= ZERO;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            addr_r  <= addr_s;
            rem_r   <= rem_s;
            data_r  <= data_s;
            valid_r <= valid_s;
            done_r  <= done_s;
        end
    end

`ifdef SCAN_LOOP_EN
    // Copies of the accepted scan range, reloaded at every loop turn.
    always_ff @(posedge clk) begin
        if (reset) begin
            base_copy_r <= ZERO;
            len_copy_r  <= ZERO;
        end else if ((state_r == IDLE) && lat_load_s) begin
            base_copy_r <= base_addr;
            len_copy_r  <= length;
        end
    end
`endif

    assign addr_b    = addr_r;
    assign we_b      = 1'b0;
    assign data_b    = ZERO;
    assign out_data  = data_r;
    assign out_valid = valid_r;
    assign done      = done_r;
    assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_bram_scan_reader.sv
// Directed bench for bram_scan_reader with a queue-based stream model and a per-cycle checker.
module tb_bram_scan_reader;

    localparam logic [15:0] SWITCHES = 16'h005A;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } word_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] base_addr = 16'h0000;
    logic [15:0] length = 16'h0000;
    logic [15:0] addr_b, data_b, rd_data, out_data;
    logic        we_b, out_valid, busy, done;

    logic [15:0] mem [0:65535];

    word_t       exp_q[$];
    word_t       rx_q[$];
    int          rx_cyc[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          busy_cnt = 0;
    int          valid_cnt = 0;
    int          stall_cnt = 0;
    logic [15:0] stall_data = 16'h0000;
    logic [15:0] stall_addr = 16'h0000;

    bram_scan_reader #(
        .WIDTH    (16),
        .READ_LAT (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .base_addr (base_addr),
        .length    (length),
        .addr_b    (addr_b),
        .we_b      (we_b),
        .data_b    (data_b),
        .rd_data   (rd_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    // Top-level read mux: one-cycle latency means data for addr_b is ready by the next edge.
    always_comb rd_data = (addr_b[9:8] == 2'b11) ? SWITCHES : mem[addr_b];

    function automatic logic [15:0] env_word(input logic [15:0] a);
        return (a[9:8] == 2'b11) ? SWITCHES : mem[a];
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle checker: expected stream, done timing, busy, stability during back-pressure.
    initial begin : compare
        logic        m_busy, exp_reset, exp_done, exp_hold, hs;
        logic [15:0] hold_data, hold_addr, m_base, m_len;
        word_t       w;
        m_busy = 1'b0; exp_reset = 1'b0; exp_done = 1'b0; exp_hold = 1'b0;
        hold_data = 16'h0; hold_addr = 16'h0; m_base = 16'h0; m_len = 16'h0;
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                check("busy", {15'd0, busy}, {15'd0, m_busy});
                check("done", {15'd0, done}, {15'd0, exp_done});
                check("we_b", {15'd0, we_b}, 16'h0000);
                check("data_b", data_b, 16'h0000);
                if (exp_reset) begin
                    check("rst_addr_b", addr_b, 16'h0000);
                    check("rst_out_data", out_data, 16'h0000);
                end
                if (!m_busy) check("idle_out_valid", {15'd0, out_valid}, 16'h0000);
                if (exp_hold) begin
                    check("hold_valid", {15'd0, out_valid}, 16'h0001);
                    check("hold_data", out_data, hold_data);
                    check("hold_addr", addr_b, hold_addr);
                end
                if (out_valid && m_busy) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_word: got %h at %h expected no word", out_data, addr_b);
                    end else begin
                        check("stream_data", out_data, exp_q[0].data);
                        check("stream_addr", addr_b, exp_q[0].addr);
                    end
                end
            end
            if (done) done_cnt++;
            if (busy) busy_cnt++;
            if (out_valid) valid_cnt++;
            if (out_valid && !out_ready) begin
                stall_cnt++;
                stall_data = out_data;
                stall_addr = addr_b;
            end
            hs = out_valid && out_ready && m_busy && !stop && !reset;
            exp_reset = reset;
            exp_done  = 1'b0;
            exp_hold  = 1'b0;
            if (reset) begin
                m_busy = 1'b0;
                exp_q.delete();
            end else if (m_busy) begin
                if (stop) begin
                    m_busy = 1'b0;
                    exp_q.delete();
                end else if (hs) begin
                    w.addr = addr_b;
                    w.data = out_data;
                    rx_q.push_back(w);
                    rx_cyc.push_back(cyc);
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    if (exp_q.size() == 0) begin
                        exp_done = 1'b1;
`ifdef SCAN_LOOP_EN
                        for (int i = 0; i < int'(m_len); i++) begin
                            w.addr = m_base + 16'(i);
                            w.data = env_word(w.addr);
                            exp_q.push_back(w);
                        end
`else
                        m_busy = 1'b0;
`endif
                    end
                end else if (out_valid) begin
                    exp_hold  = 1'b1;
                    hold_data = out_data;
                    hold_addr = addr_b;
                end
            end else if (start && !stop) begin
                if (length == 16'h0000) begin
                    exp_done = 1'b1;
                end else begin
                    m_busy = 1'b1;
                    m_base = base_addr;
                    m_len  = length;
                    for (int i = 0; i < int'(length); i++) begin
                        w.addr = base_addr + 16'(i);
                        w.data = env_word(w.addr);
                        exp_q.push_back(w);
                    end
                end
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_scan(input logic [15:0] b, input logic [15:0] n);
        base_addr = b;
        length    = n;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 300) begin
            tick();
            k++;
        end
        check(name, {15'd0, busy}, 16'h0000);
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        while (!out_valid && k < 50) begin
            tick();
            k++;
        end
        check(name, {15'd0, out_valid}, 16'h0001);
    endtask

    initial begin : stimulus
        int          r0, d0, s0, b0, v0, k;
        logic [15:0] t1_data [4];
        logic [15:0] t3_addr [4];
        t1_data = '{16'h00A1, 16'h00B2, 16'h00C3, 16'h00D4};
        t3_addr = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'h3C00;
        mem[16'h0010] = 16'h00A1;
        mem[16'h0011] = 16'h00B2;
        mem[16'h0012] = 16'h00C3;
        mem[16'h0013] = 16'h00D4;
        mem[16'h0000] = 16'h1111;
        mem[16'h0001] = 16'h2222;

        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("reset_addr_b", addr_b, 16'h0000);
        check("reset_busy", {15'd0, busy}, 16'h0000);

        // Basic four-word scan at full rate
        r0 = rx_q.size(); d0 = done_cnt;
        out_ready = 1'b1;
        start_scan(16'h0010, 16'd4);
        wait_idle("t1_idle");
        tick(); tick();
        check("t1_count", 16'(rx_q.size() - r0), 16'd4);
        for (int i = 0; i < 4; i++) begin
            if (r0 + i < rx_q.size()) begin
                check("t1_data", rx_q[r0 + i].data, t1_data[i]);
                check("t1_addr", rx_q[r0 + i].addr, 16'h0010 + 16'(i));
                if (i > 0) check("t1_spacing", 16'(rx_cyc[r0 + i] - rx_cyc[r0 + i - 1]), 16'd2);
            end
        end
        check("t1_done_pulses", 16'(done_cnt - d0), 16'd1);

        // Back-pressure on word 2 for five cycles
        r0 = rx_q.size(); d0 = done_cnt; s0 = stall_cnt;
        start_scan(16'h0010, 16'd4);
        k = 0;
        while ((rx_q.size() - r0) < 1 && k < 50) begin
            tick();
            k++;
        end
        out_ready = 1'b0;
        wait_valid("t2_valid");
        repeat (5) tick();
        out_ready = 1'b1;
        wait_idle("t2_idle");
        tick(); tick();
        check("t2_stall_cycles", 16'(stall_cnt - s0), 16'd5);
        check("t2_stall_data", stall_data, 16'h00B2);
        check("t2_stall_addr", stall_addr, 16'h0011);
        check("t2_count", 16'(rx_q.size() - r0), 16'd4);
        check("t2_done_pulses", 16'(done_cnt - d0), 16'd1);

        // Address wrap through the top of memory, plus a start while busy
        r0 = rx_q.size();
        start_scan(16'hFFFE, 16'd4);
        base_addr = 16'h0040;
        length    = 16'd2;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        wait_idle("t3_idle");
        tick(); tick();
        check("t3_count", 16'(rx_q.size() - r0), 16'd4);
        for (int i = 0; i < 4; i++) begin
            if (r0 + i < rx_q.size()) check("t3_addr", rx_q[r0 + i].addr, t3_addr[i]);
        end
        if (r0 + 3 < rx_q.size()) begin
            check("t3_io_word", rx_q[r0].data, 16'h005A);
            check("t3_word0", rx_q[r0 + 2].data, 16'h1111);
            check("t3_word1", rx_q[r0 + 3].data, 16'h2222);
        end

        // Zero-length start
        d0 = done_cnt; b0 = busy_cnt; v0 = valid_cnt;
        start_scan(16'h0040, 16'd0);
        tick(); tick(); tick();
        check("t4_done_cycles", 16'(done_cnt - d0), 16'd1);
        check("t4_busy_cycles", 16'(busy_cnt - b0), 16'd0);
        check("t4_valid_cycles", 16'(valid_cnt - v0), 16'd0);

        // Stop in the second HOLD cycle, racing a handshake
        r0 = rx_q.size(); d0 = done_cnt;
        out_ready = 1'b0;
        start_scan(16'h0020, 16'd8);
        wait_valid("t5_valid");
        tick();
        stop      = 1'b1;
        out_ready = 1'b1;
        tick();
        stop      = 1'b0;
        check("t5_valid_after_stop", {15'd0, out_valid}, 16'h0000);
        check("t5_busy_after_stop", {15'd0, busy}, 16'h0000);
        tick(); tick();
        check("t5_no_done", 16'(done_cnt - d0), 16'd0);
        check("t5_no_accept", 16'(rx_q.size() - r0), 16'd0);
        r0 = rx_q.size(); d0 = done_cnt;
        start_scan(16'h0010, 16'd4);
        wait_idle("t5b_idle");
        tick(); tick();
        check("t5b_count", 16'(rx_q.size() - r0), 16'd4);
        if (r0 + 3 < rx_q.size()) begin
            check("t5b_first", rx_q[r0].data, 16'h00A1);
            check("t5b_last", rx_q[r0 + 3].data, 16'h00D4);
        end
        check("t5b_done_pulses", 16'(done_cnt - d0), 16'd1);

        // Simultaneous start and stop in IDLE
        b0 = busy_cnt;
        base_addr = 16'h0010;
        length    = 16'd4;
        start     = 1'b1;
        stop      = 1'b1;
        tick();
        start     = 1'b0;
        stop      = 1'b0;
        tick();
        check("t6_no_start", 16'(busy_cnt - b0), 16'd0);

        // Reset in the middle of a scan
        start_scan(16'h0020, 16'd8);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t7_addr_b", addr_b, 16'h0000);
        check("t7_out_data", out_data, 16'h0000);
        check("t7_out_valid", {15'd0, out_valid}, 16'h0000);
        check("t7_busy", {15'd0, busy}, 16'h0000);
        check("t7_done", {15'd0, done}, 16'h0000);
        tick();

`ifdef SCAN_LOOP_EN
        // Looping single-word scan of the switch register
        r0 = rx_q.size(); d0 = done_cnt;
        start_scan(16'h0300, 16'd1);
        k = 0;
        while ((done_cnt - d0) < 3 && k < 100) begin
            tick();
            k++;
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        check("t8_loops", {15'd0, (done_cnt - d0) >= 3}, 16'h0001);
        for (int i = 0; i < 3; i++) begin
            if (r0 + i < rx_q.size()) check("t8_data", rx_q[r0 + i].data, 16'h005A);
        end
        check("t8_busy_after_stop", {15'd0, busy}, 16'h0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
